// File: rtl/counter_seq_checker.sv
// Receive-side checker for a paired up/down counter: predicts the next value pair,
// flags step/skip/complement errors. Define CNT_CHECK_DWN_EN to also check the down path.
module counter_seq_checker #(
   parameter int COUNT_WIDTH   = 3,
   parameter int ERR_CNT_WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     enable,
   input  logic [COUNT_WIDTH-1:0]   count_up_in,
   input  logic [COUNT_WIDTH-1:0]   count_dwn_in,
   input  logic                     clear,
   output logic                     locked,
   output logic                     mismatch,
   output logic                     fault,
   output logic                     wrap,
   output logic [ERR_CNT_WIDTH-1:0] err_count
);

   typedef enum logic {
      UNLOCKED = 1'b0,
      LOCKED   = 1'b1
   } state_t;

   state_t                   state_q, state_d;
   logic [COUNT_WIDTH-1:0]   exp_up_q, exp_up_d;
   logic                     mismatch_q, mismatch_d;
   logic                     fault_q, fault_d;
   logic                     wrap_q, wrap_d;
   logic [ERR_CNT_WIDTH-1:0] err_count_q, err_count_d;

   logic [COUNT_WIDTH-1:0]   step;
   logic                     pair_ok;
   logic                     sample_match;

   assign step = {{(COUNT_WIDTH-1){1'b0}}, enable};

`ifdef CNT_CHECK_DWN_EN
   logic [COUNT_WIDTH-1:0]   exp_dwn_q, exp_dwn_d;

   assign pair_ok      = (count_dwn_in == ~count_up_in);
   assign sample_match = (count_up_in == exp_up_q) && (count_dwn_in == exp_dwn_q);
`else
   // Down path is not checked in this build; any sample is acceptable for acquisition.
   logic unused_dwn;

   assign unused_dwn   = ^count_dwn_in;
   assign pair_ok      = 1'b1;
   assign sample_match = (count_up_in == exp_up_q);
`endif

   always_comb begin
      state_d     = state_q;
      exp_up_d    = exp_up_q;
`ifdef CNT_CHECK_DWN_EN
      exp_dwn_d   = exp_dwn_q;
`endif
      mismatch_d  = 1'b0;
      wrap_d      = 1'b0;
      fault_d     = fault_q;
      err_count_d = err_count_q;

      if (clear) begin
         state_d     = UNLOCKED;
         fault_d     = 1'b0;
         err_count_d = '0;
      end else begin
         case (state_q)
            UNLOCKED: begin
               if (pair_ok) begin
                  state_d   = LOCKED;
                  exp_up_d  = count_up_in + step;
`ifdef CNT_CHECK_DWN_EN
                  exp_dwn_d = count_dwn_in - step;
`endif
               end
            end
            LOCKED: begin
               if (sample_match) begin
                  exp_up_d  = count_up_in + step;
`ifdef CNT_CHECK_DWN_EN
                  exp_dwn_d = count_dwn_in - step;
`endif
                  wrap_d    = enable && (count_up_in == {COUNT_WIDTH{1'b1}});
               end else begin
                  state_d    = UNLOCKED;
                  mismatch_d = 1'b1;
                  fault_d    = 1'b1;
                  if (err_count_q != {ERR_CNT_WIDTH{1'b1}}) begin
                     err_count_d = err_count_q + {{(ERR_CNT_WIDTH-1){1'b0}}, 1'b1};
                  end
               end
            end
            default: state_d = UNLOCKED;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= UNLOCKED;
         exp_up_q    <= '0;
         mismatch_q  <= 1'b0;
         fault_q     <= 1'b0;
         wrap_q      <= 1'b0;
         err_count_q <= '0;
      end else begin
         state_q     <= state_d;
         exp_up_q    <= exp_up_d;
         mismatch_q  <= mismatch_d;
         fault_q     <= fault_d;
         wrap_q      <= wrap_d;
         err_count_q <= err_count_d;
      end
   end

`ifdef CNT_CHECK_DWN_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exp_dwn_q <= '0;
      end else begin
         exp_dwn_q <= exp_dwn_d;
      end
   end
`endif

   assign locked    = (state_q == LOCKED);
   assign mismatch  = mismatch_q;
   assign fault     = fault_q;
   assign wrap      = wrap_q;
   assign err_count = err_count_q;

endmodule

// File: tb/tb_counter_seq_checker.sv
// Directed bench for counter_seq_checker (COUNT_WIDTH=3, ERR_CNT_WIDTH=2) driven by an ideal counter.
module tb_counter_seq_checker;

   logic       clk;
   logic       rst_n;
   logic       enable;
   logic [2:0] count_up_in;
   logic [2:0] count_dwn_in;
   logic       clear;
   logic       locked;
   logic       mismatch;
   logic       fault;
   logic       wrap;
   logic [1:0] err_count;

   int tests  = 0;
   int failed = 0;

   logic [2:0] cu;
   logic [2:0] pre;
   logic [2:0] bad;
   logic [5:0] pat;
   logic       en;
   logic       dwn_checked;

   counter_seq_checker #(
      .COUNT_WIDTH   (3),
      .ERR_CNT_WIDTH (2)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .enable       (enable),
      .count_up_in  (count_up_in),
      .count_dwn_in (count_dwn_in),
      .clear        (clear),
      .locked       (locked),
      .mismatch     (mismatch),
      .fault        (fault),
      .wrap         (wrap),
      .err_count    (err_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Present one sample, let the edge take it, return 1 time unit later.
   task automatic tick(input logic e, input logic [2:0] up, input logic [2:0] dn, input logic clr);
      enable       = e;
      count_up_in  = up;
      count_dwn_in = dn;
      clear        = clr;
      @(posedge clk);
      #1;
   endtask

   task automatic good(input logic e);
      tick(e, cu, ~cu, 1'b0);
      cu = cu + {2'b00, e};
   endtask

   initial begin
`ifdef CNT_CHECK_DWN_EN
      dwn_checked = 1'b1;
`else
      dwn_checked = 1'b0;
`endif
      pat = 6'b011001;
      cu  = 3'd0;
      rst_n = 1'b0;
      enable = 1'b0;
      count_up_in = 3'd0;
      count_dwn_in = 3'd0;
      clear = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_locked",   32'(locked),    32'd0);
      check("rst_mismatch", 32'(mismatch),  32'd0);
      check("rst_fault",    32'(fault),     32'd0);
      check("rst_wrap",     32'(wrap),      32'd0);
      check("rst_err",      32'(err_count), 32'd0);
      rst_n = 1'b1;

      // 1: enable held high, wrap every 8 cycles once locked
      for (int i = 1; i <= 24; i++) begin
         good(1'b1);
         check("t1_locked", 32'(locked),    32'd1);
         check("t1_err",    32'(err_count), 32'd0);
         check("t1_wrap",   32'(wrap),      (i % 8 == 0) ? 32'd1 : 32'd0);
      end

      // 2: enable pattern 1,0,0,1,1,0
      for (int i = 0; i < 50; i++) begin
         en  = pat[i % 6];
         pre = cu;
         good(en);
         check("t2_mismatch", 32'(mismatch), 32'd0);
         check("t2_wrap",     32'(wrap),     32'((pre == 3'd7) && en));
      end
      check("t2_fault",  32'(fault),  32'd0);
      check("t2_locked", 32'(locked), 32'd1);

      // 3: expected up value 3, present 5
      for (int i = 0; i < 8 && cu != 3'd3; i++) good(1'b1);
      tick(1'b1, 3'd5, ~cu, 1'b0);
      cu = cu + 3'd1;
      check("t3_mismatch", 32'(mismatch),  32'd1);
      check("t3_fault",    32'(fault),     32'd1);
      check("t3_err",      32'(err_count), 32'd1);
      check("t3_locked",   32'(locked),    32'd0);
      good(1'b1);
      check("t3_mis_width", 32'(mismatch), 32'd0);
      check("t3_relock",    32'(locked),   32'd1);
      check("t3_fault_st",  32'(fault),    32'd1);

      // 4: five more separated errors, 2-bit counter saturates at 3
      for (int k = 1; k <= 5; k++) begin
         bad = cu + 3'd3;
         tick(1'b1, bad, ~cu, 1'b0);
         cu = cu + 3'd1;
         check("t4_mismatch", 32'(mismatch),  32'd1);
         check("t4_err",      32'(err_count), (k + 1 > 3) ? 32'd3 : 32'(k + 1));
         check("t4_fault",    32'(fault),     32'd1);
         good(1'b1);
         check("t4_relock",   32'(locked),    32'd1);
         check("t4_mis_off",  32'(mismatch),  32'd0);
      end

      // 5: clear on the same edge as a bad sample
      bad = cu + 3'd3;
      tick(1'b1, bad, ~cu, 1'b1);
      cu = cu + 3'd1;
      check("t5_mismatch", 32'(mismatch),  32'd0);
      check("t5_fault",    32'(fault),     32'd0);
      check("t5_err",      32'(err_count), 32'd0);
      check("t5_locked",   32'(locked),    32'd0);
      check("t5_wrap",     32'(wrap),      32'd0);
      // inconsistent pair while unlocked: no error; acquires only if down path is unchecked
      tick(1'b1, cu, cu, 1'b0);
      cu = cu + 3'd1;
      check("t5_incons_locked", 32'(locked),    dwn_checked ? 32'd0 : 32'd1);
      check("t5_incons_err",    32'(err_count), 32'd0);
      check("t5_incons_mis",    32'(mismatch),  32'd0);
      good(1'b1);
      check("t5_acq_locked", 32'(locked),   32'd1);
      check("t5_acq_mis",    32'(mismatch), 32'd0);

      // 6: corrupt only the down value
      tick(1'b1, cu, ~cu ^ 3'b001, 1'b0);
      cu = cu + 3'd1;
      check("t6_mismatch", 32'(mismatch),  dwn_checked ? 32'd1 : 32'd0);
      check("t6_err",      32'(err_count), dwn_checked ? 32'd1 : 32'd0);
      check("t6_locked",   32'(locked),    dwn_checked ? 32'd0 : 32'd1);
      good(1'b1);
      check("t6_relock",   32'(locked),    32'd1);

      // 7: asynchronous reset mid-sequence
      bad = cu + 3'd3;
      tick(1'b1, bad, ~cu, 1'b0);
      cu = cu + 3'd1;
      check("t7_pre_mis", 32'(mismatch), 32'd1);
      #3;
      rst_n = 1'b0;
      #1;
      check("t7_locked",   32'(locked),    32'd0);
      check("t7_mismatch", 32'(mismatch),  32'd0);
      check("t7_fault",    32'(fault),     32'd0);
      check("t7_err",      32'(err_count), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cu = 3'd0;
      good(1'b0);
      check("t7_reacq", 32'(locked), 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
